alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//   Upstream issue stage for the ALU. Accepts one operation at a time over a
//   valid/ready command port and drives registered A/B/AHigh/mode into the ALU.
//   Waits a fixed ALU latency, captures ALU_out/cf/sf, and presents the result
//   on a valid/ready response port. Operands are held stable for the whole
//   operation.
// PARAMETERS
//   DATA_W  32  operand width (A, B, AHigh); result width is 2*DATA_W
//   LAT     2   clk edges from alu_* operands changing to ALU_out valid; legal >=1
// PORTS
//   clk        in   1         clock, rising edge
//   rst        in   1         reset, synchronous, active-low
//   cmd_valid  in   1         command offered
//   cmd_ready  out  1         controller can accept a command
//   cmd_mode   in   4         ALU mode, 0..15, passed through unchanged
//   cmd_a      in   DATA_W    operand A
//   cmd_b      in   DATA_W    operand B
//   cmd_ahigh  in   DATA_W    high operand word (AHigh)
//   alu_A      out  DATA_W    to ALU .A, registered
//   alu_B      out  DATA_W    to ALU .B, registered
//   alu_AHigh  out  DATA_W    to ALU .AHigh, registered
//   alu_mode   out  4         to ALU .mode, registered
//   alu_out    in   2*DATA_W  from ALU .ALU_out
//   alu_cf     in   1         from ALU .cf
//   alu_sf     in   1         from ALU .sf
//   rsp_valid  out  1         result available
//   rsp_ready  in   1         consumer takes result
//   rsp_data   out  2*DATA_W  captured ALU_out
//   rsp_cf     out  1         captured cf
//   rsp_sf     out  1         captured sf
//   busy       out  1         state != IDLE
// BEHAVIOUR
//   Reset (rst=0 at a clk edge): state=IDLE, counter=0, and all registered
//     outputs cleared (alu_*, rsp_*, busy). cmd_ready=0 while rst=0.
//     Reset has priority over all other events. Reset mid-operation aborts the
//     operation; no response is produced.
//   IDLE: cmd_ready=1. On an edge with cmd_valid=1:
//     - alu_A<=cmd_a, alu_B<=cmd_b, alu_AHigh<=cmd_ahigh, alu_mode<=cmd_mode.
//     - cnt<=LAT; state goes to WAIT.
//   WAIT: cmd_ready=0, and cmd_valid is ignored.
//     - cnt decrements on each edge.
//     - On the edge where cnt==1: rsp_data<=alu_out, rsp_cf<=alu_cf,
//       rsp_sf<=alu_sf; state goes to RESP.
//   RESP: rsp_valid=1 and rsp_* are held stable.
//     - On an edge with rsp_ready=1, state goes to IDLE.
//     - rsp_ready held high in advance completes on the first RESP edge.
//   Timing: rsp_valid rises LAT+1 edges after the accept edge. Minimum
//     spacing between accepts is LAT+2 cycles; there is no IDLE/RESP bypass.
//   alu_* hold the last operands after completion (no return to 0) until the
//     next accept.
//   rsp_data/cf/sf hold their values after the handshake until the next capture.
//   State encoding: IDLE=0, WAIT=1, RESP=2. Value 3 is illegal and goes to IDLE.
// CONFIGURATION
//   ALU_STICKY_FLAGS_EN defined:
//     - adds ports sticky_clr (in, 1), sticky_cf (out, 1), sticky_sf (out, 1).
//     - At each capture edge: sticky_cf|=alu_cf, sticky_sf|=alu_sf.
//     - sticky_clr=1 clears both; if a capture occurs on the same edge, the
//       captured flags are the new value (capture wins).
//     - Both reset to 0.
//   ALU_STICKY_FLAGS_EN undefined: these ports and registers do not exist.
// TESTING (bench ALU stub: alu_out={alu_AHigh, alu_A+alu_B}, cf=carry,
//          sf=bit31 of the sum, each delayed LAT edges; LAT=2)
//   1. rst=0 for 3 edges, then rst=1 -> all outputs 0, cmd_ready=1, busy=0.
//   2. a=3FCCCCCC, b=3F999999, ahigh=0, mode=0, rsp_ready=1
//      -> rsp_valid rises at edge 3 after accept;
//      -> rsp_data=0000_0000_7F66_6665, cf=0, sf=0.
//   3. a=FFFFFFFF, b=1, ahigh=12345678, mode=15
//      -> alu_mode=F during WAIT; rsp_data=1234_5678_0000_0000, cf=1.
//   4. rsp_ready=0 for 5 cycles during RESP, cmd_valid=1 throughout
//      -> rsp_* stable and cmd_ready=0;
//      -> next accept occurs only after the edge with rsp_ready=1.
//   5. rst=0 asserted in WAIT (cnt=1) -> no rsp_valid; after release, state is
//      IDLE and cmd_ready=1.
//   6. [ALU_STICKY_FLAGS_EN] run test 3, then test 2
//      -> sticky_cf stays 1;
//      -> sticky_clr=1 pulse -> sticky_cf=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the ALU: accepts one command, holds the operands for a fixed latency,
// captures the result and offers it on a response port. Optional macro: ALU_STICKY_FLAGS_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; alu_* hold the last operands
// WAIT  | operands applied to the ALU, counting down the ALU latency
// RESP  | result captured in rsp_*, waiting for rsp_ready
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_mode,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    input  logic [DATA_W-1:0]   cmd_ahigh,
    output logic [DATA_W-1:0]   alu_A,
    output logic [DATA_W-1:0]   alu_B,
    output logic [DATA_W-1:0]   alu_AHigh,
    output logic [3:0]          alu_mode,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                alu_cf,
    input  logic                alu_sf,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_cf,
    output logic                rsp_sf,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic                sticky_clr,
    output logic                sticky_cf,
    output logic                sticky_sf,
`endif
    output logic                busy
);

    localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // The ALU output is valid on the last counted edge, so capture there.
                if (cnt_q == CNT_ONE) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            alu_A     <= '0;
            alu_B     <= '0;
            alu_AHigh <= '0;
            alu_mode  <= '0;
            rsp_data  <= '0;
            rsp_cf    <= 1'b0;
            rsp_sf    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                alu_A     <= cmd_a;
                alu_B     <= cmd_b;
                alu_AHigh <= cmd_ahigh;
                alu_mode  <= cmd_mode;
            end
            if (capture) begin
                rsp_data <= alu_out;
                rsp_cf   <= alu_cf;
                rsp_sf   <= alu_sf;
            end
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // A capture on the same edge as a clear leaves only the newly captured flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky_cf <= 1'b0;
            sticky_sf <= 1'b0;
        end else if (capture) begin
            sticky_cf <= (sticky_clr ? 1'b0 : sticky_cf) | alu_cf;
            sticky_sf <= (sticky_clr ? 1'b0 : sticky_sf) | alu_sf;
        end else if (sticky_clr) begin
            sticky_cf <= 1'b0;
            sticky_sf <= 1'b0;
        end
    end
`endif

    assign cmd_ready = rst && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of the accept / latency / handshake rules.
module tb_alu_issue_ctrl;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk, rst, cmd_valid, cmd_ready;
    logic [3:0]    cmd_mode, alu_mode;
    logic [DW-1:0] cmd_a, cmd_b, cmd_ahigh, alu_A, alu_B, alu_AHigh;
    logic [2*DW-1:0] alu_out, rsp_data;
    logic          alu_cf, alu_sf, rsp_valid, rsp_ready, rsp_cf, rsp_sf, busy;
`ifdef ALU_STICKY_FLAGS_EN
    logic          sticky_clr, sticky_cf, sticky_sf;
`endif

    int checks = 0;
    int errors = 0;

    // transaction model state
    bit              m_have;
    int              m_age;
    logic [DW-1:0]   m_a, m_b, m_ah;
    logic [3:0]      m_mode;
    logic [2*DW-1:0] m_data;
    logic            m_cf, m_sf;

    alu_issue_ctrl #(.DATA_W(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ahigh(cmd_ahigh),
        .alu_A(alu_A), .alu_B(alu_B), .alu_AHigh(alu_AHigh), .alu_mode(alu_mode),
        .alu_out(alu_out), .alu_cf(alu_cf), .alu_sf(alu_sf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cf(rsp_cf), .rsp_sf(rsp_sf),
`ifdef ALU_STICKY_FLAGS_EN
        .sticky_clr(sticky_clr), .sticky_cf(sticky_cf), .sticky_sf(sticky_sf),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: one register stage, so the result is valid LAT edges after the
    // operands change (counting the edge that changes them).
    logic [DW:0]   stub_sum;
    logic [DW-1:0] stub_high;
    always_ff @(posedge clk) begin
        stub_sum  <= {1'b0, alu_A} + {1'b0, alu_B};
        stub_high <= alu_AHigh;
    end
    assign alu_out = {stub_high, stub_sum[DW-1:0]};
    assign alu_cf  = stub_sum[DW];
    assign alu_sf  = stub_sum[DW-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge();
        logic [DW:0] s;
        if (m_have) begin
            if (m_age >= LAT && rsp_ready) begin
                m_have = 1'b0;
            end else begin
                m_age++;
                if (m_age == LAT) begin
                    s      = {1'b0, m_a} + {1'b0, m_b};
                    m_data = {m_ah, s[DW-1:0]};
                    m_cf   = s[DW];
                    m_sf   = s[DW-1];
                end
            end
        end else if (cmd_valid) begin
            m_have = 1'b1;
            m_age  = 0;
            m_a    = cmd_a;
            m_b    = cmd_b;
            m_ah   = cmd_ahigh;
            m_mode = cmd_mode;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_ahigh = '0; cmd_mode = '0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (3) tick();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low: got %b expected 0", cmd_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 100", {cmd_ready, busy, rsp_valid});
        end
        checks++;
        if ({alu_A, alu_B, alu_AHigh, alu_mode} !== '0) begin
            errors++; $display("FAIL reset_alu: got %h/%h/%h/%h expected 0", alu_A, alu_B, alu_AHigh, alu_mode);
        end
        checks++;
        if ({rsp_data, rsp_cf, rsp_sf} !== '0) begin
            errors++; $display("FAIL reset_rsp: got %h cf=%b sf=%b expected 0", rsp_data, rsp_cf, rsp_sf);
        end
`ifdef ALU_STICKY_FLAGS_EN
        checks++;
        if ({sticky_cf, sticky_sf} !== 2'b00) begin
            errors++; $display("FAIL reset_sticky: got %b expected 00", {sticky_cf, sticky_sf});
        end
`endif
    endtask

    // One command with rsp_ready held high; the response is expected on edge 3
    // counting the accept edge as edge 1.
    task automatic test_single_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] ah, input logic [3:0] mode,
                                  input logic [2*DW-1:0] exp_data, input logic exp_cf, input logic exp_sf);
        cmd_a = a; cmd_b = b; cmd_ahigh = ah; cmd_mode = mode;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s idle_ready: got %b expected 1", name, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_a = ~a; cmd_b = ~b; cmd_ahigh = ~ah; cmd_mode = ~mode;
        checks++;
        if ({alu_A, alu_B, alu_AHigh, alu_mode} !== {a, b, ah, mode}) begin
            errors++; $display("FAIL %s alu_operands: got %h %h %h %h expected %h %h %h %h",
                               name, alu_A, alu_B, alu_AHigh, alu_mode, a, b, ah, mode);
        end
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b010) begin
            errors++; $display("FAIL %s after_accept: got %b expected 010", name, {cmd_ready, busy, rsp_valid});
        end
        tick();
        checks++;
        if ({rsp_valid, alu_mode, alu_A} !== {1'b0, mode, a}) begin
            errors++; $display("FAIL %s wait_edge2: got valid=%b mode=%h A=%h expected 0 %h %h",
                               name, rsp_valid, alu_mode, alu_A, mode, a);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_cf, rsp_sf} !== {1'b1, exp_data, exp_cf, exp_sf}) begin
            errors++; $display("FAIL %s response: got v=%b %h cf=%b sf=%b expected 1 %h cf=%b sf=%b",
                               name, rsp_valid, rsp_data, rsp_cf, rsp_sf, exp_data, exp_cf, exp_sf);
        end
        tick();
        checks++;
        if ({cmd_ready, busy, rsp_valid, rsp_data, alu_A} !== {3'b100, exp_data, a}) begin
            errors++; $display("FAIL %s done_hold: got ctrl=%b data=%h A=%h expected 100 %h %h",
                               name, {cmd_ready, busy, rsp_valid}, rsp_data, alu_A, exp_data, a);
        end
    endtask

    task automatic test_backpressure();
        logic [2*DW-1:0] r1;
        r1 = {32'hA5A5A5A5, 32'h33333333};
        rsp_ready = 1'b0; cmd_valid = 1'b1;
        cmd_a = 32'h11111111; cmd_b = 32'h22222222; cmd_ahigh = 32'hA5A5A5A5; cmd_mode = 4'd3;
        tick();
        cmd_a = 32'hDEADBEEF; cmd_b = 32'h21524111; cmd_ahigh = 32'h0F0F0F0F; cmd_mode = 4'd9;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({rsp_valid, cmd_ready, rsp_data, rsp_cf, rsp_sf, alu_A} !== {2'b10, r1, 2'b00, 32'h11111111}) begin
                errors++; $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b %h cf=%b sf=%b A=%h expected 1 0 %h 0 0 11111111",
                                   i, rsp_valid, cmd_ready, rsp_data, rsp_cf, rsp_sf, alu_A, r1);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, cmd_ready, busy, alu_A} !== {3'b010, 32'h11111111}) begin
            errors++; $display("FAIL bp_release: got v=%b rdy=%b busy=%b A=%h expected 0 1 0 11111111",
                               rsp_valid, cmd_ready, busy, alu_A);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, alu_A, alu_mode} !== {1'b1, 32'hDEADBEEF, 4'd9}) begin
            errors++; $display("FAIL bp_next_accept: got busy=%b A=%h mode=%h expected 1 deadbeef 9", busy, alu_A, alu_mode);
        end
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_cf, rsp_sf} !== {1'b1, 32'h0F0F0F0F, 32'h0, 2'b10}) begin
            errors++; $display("FAIL bp_second_rsp: got v=%b %h cf=%b sf=%b expected 1 0f0f0f0f00000000 1 0",
                               rsp_valid, rsp_data, rsp_cf, rsp_sf);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        rsp_ready = 1'b1; cmd_valid = 1'b1;
        cmd_a = 32'h00000005; cmd_b = 32'h00000007; cmd_ahigh = 32'hCAFEF00D; cmd_mode = 4'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if ({busy, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL abort_in_wait: got busy=%b v=%b expected 1 0", busy, rsp_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, busy, cmd_ready, alu_A, rsp_data} !== '0) begin
            errors++; $display("FAIL abort_reset: got v=%b busy=%b rdy=%b A=%h data=%h expected all 0",
                               rsp_valid, busy, cmd_ready, alu_A, rsp_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL abort_release_ready: got %b expected 1", cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
                errors++; $display("FAIL abort_no_rsp cycle %0d: got %b expected 001", i, {rsp_valid, busy, cmd_ready});
            end
        end
    endtask

    task automatic test_random_traffic(input string name, input int n, input int vpct, input int rpct);
        cmd_valid = 1'b0; rsp_ready = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        m_have = 1'b0; m_age = 0;
        m_a = '0; m_b = '0; m_ah = '0; m_mode = '0;
        m_data = '0; m_cf = 1'b0; m_sf = 1'b0;
        for (int i = 0; i < n; i++) begin
            cmd_valid = ($urandom_range(99) < vpct);
            rsp_ready = ($urandom_range(99) < rpct);
            cmd_a     = $urandom;
            cmd_b     = $urandom;
            cmd_ahigh = $urandom;
            cmd_mode  = 4'($urandom_range(15));
            model_edge();
            tick();
            checks++;
            if ({cmd_ready, busy, rsp_valid} !== {~m_have, m_have, m_have && (m_age >= LAT)}) begin
                errors++; $display("FAIL %s ctrl cycle %0d: got rdy/busy/v=%b expected %b", name, i,
                                   {cmd_ready, busy, rsp_valid}, {~m_have, m_have, m_have && (m_age >= LAT)});
            end
            checks++;
            if ({alu_AHigh, alu_A, alu_B, alu_mode} !== {m_ah, m_a, m_b, m_mode}) begin
                errors++; $display("FAIL %s alu cycle %0d: got %h %h %h %h expected %h %h %h %h", name, i,
                                   alu_AHigh, alu_A, alu_B, alu_mode, m_ah, m_a, m_b, m_mode);
            end
            checks++;
            if ({rsp_data, rsp_cf, rsp_sf} !== {m_data, m_cf, m_sf}) begin
                errors++; $display("FAIL %s rsp cycle %0d: got %h cf=%b sf=%b expected %h cf=%b sf=%b", name, i,
                                   rsp_data, rsp_cf, rsp_sf, m_data, m_cf, m_sf);
            end
        end
        cmd_valid = 1'b0;
    endtask

`ifdef ALU_STICKY_FLAGS_EN
    task automatic test_sticky();
        rst = 1'b0; cmd_valid = 1'b0; sticky_clr = 1'b0;
        tick();
        rst = 1'b1;
        test_single_op("sticky_op3", 32'hFFFFFFFF, 32'h00000001, 32'h12345678, 4'hF,
                       64'h12345678_00000000, 1'b1, 1'b0);
        checks++;
        if ({sticky_cf, sticky_sf} !== 2'b10) begin
            errors++; $display("FAIL sticky_after_carry: got %b expected 10", {sticky_cf, sticky_sf});
        end
        test_single_op("sticky_op2", 32'h3FCCCCCC, 32'h3F999999, 32'h0, 4'h0,
                       64'h00000000_7F666665, 1'b0, 1'b0);
        checks++;
        if ({sticky_cf, sticky_sf} !== 2'b10) begin
            errors++; $display("FAIL sticky_holds: got %b expected 10", {sticky_cf, sticky_sf});
        end
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        checks++;
        if ({sticky_cf, sticky_sf} !== 2'b00) begin
            errors++; $display("FAIL sticky_clear: got %b expected 00", {sticky_cf, sticky_sf});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op("basic_add", 32'h3FCCCCCC, 32'h3F999999, 32'h0, 4'h0,
                       64'h00000000_7F666665, 1'b0, 1'b0);
        test_single_op("carry_mode15", 32'hFFFFFFFF, 32'h00000001, 32'h12345678, 4'hF,
                       64'h12345678_00000000, 1'b1, 1'b0);
        test_single_op("sign_bit", 32'h7FFFFFFF, 32'h00000001, 32'h0000ABCD, 4'h6,
                       64'h0000ABCD_80000000, 1'b0, 1'b1);
        test_backpressure();
        test_reset_abort();
        test_random_traffic("random", 400, 60, 50);
        test_random_traffic("back_to_back", 60, 100, 100);
`ifdef ALU_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
